// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the program-memory loader,
// aligned with the 6-bit PC and the 64-word program memory.
package prog_loader_pkg;

  localparam int ADDR_W         = 6;
  localparam int DEPTH          = 1 << ADDR_W;
  localparam int BYTES_PER_WORD = 2;
  localparam int DATA_W         = 8 * BYTES_PER_WORD;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs bytes big-endian into DATA_W words and emits a registered
// one-cycle word_valid pulse the cycle after the completing byte.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              beat,
  input  logic [7:0]        in_data,
  output logic              last_byte,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              word_valid_q, word_valid_d;
  logic [DATA_W-1:0] shifted;

  assign last_byte  = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  assign shifted    = {sreg_q[DATA_W-9:0], in_data};
  assign word_valid = word_valid_q;
  assign word       = word_q;

  always_comb begin
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (beat) begin
      sreg_d = shifted;
      if (last_byte) begin
        cnt_d        = '0;
        word_d       = shifted;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sreg_q       <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads DEPTH words into program memory from a byte stream while holding
// the CPU in reset. Handshake: a byte moves when in_valid & in_ready at posedge.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_loaded
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              clear;
  logic              beat;
  logic              last_byte;
  logic              word_valid;

  assign in_ready     = (state_q == LOAD);
  assign beat         = in_valid && in_ready;
  assign cpu_hold     = (state_q == LOAD) || (state_q == FLUSH);
  assign busy         = cpu_hold;
  assign done         = (state_q == DONE);
  assign mem_we       = word_valid;
  assign mem_addr     = mem_addr_q;
  assign words_loaded = words_loaded_q;

  prog_loader_byte_packer u_packer (
    .CLK        (CLK),
    .RST        (RST),
    .clear      (clear),
    .beat       (beat),
    .in_data    (in_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (mem_wdata)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    mem_addr_d     = mem_addr_q;
    words_loaded_d = words_loaded_q;
    clear          = 1'b0;
    // Counters advance at the end of the write cycle; the last word wraps addr to 0.
    if (word_valid) begin
      addr_d         = addr_q + ADDR_W'(1);
      words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = LOAD;
          clear          = 1'b1;
          addr_d         = '0;
          mem_addr_d     = '0;
          words_loaded_d = '0;
        end
      end
      LOAD: begin
        if (beat && last_byte) begin
          mem_addr_d = addr_q;
          if (addr_q == ADDR_W'(DEPTH - 1)) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      mem_addr_q     <= '0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      mem_addr_q     <= mem_addr_d;
      words_loaded_q <= words_loaded_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full sessions, gapped table vectors,
// ignored start, mid-session reset and restart after done.
module tb_prog_loader;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [6:0]  words_loaded;

  int n_cmp = 0;
  int n_err = 0;
  logic        sb_en = 1'b0;
  logic        prev_we = 1'b0;
  logic [21:0] exp_q[$];

  prog_loader dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge CLK) begin
    if (mem_we && prev_we) chk("we_back_to_back", 32'd1, 32'd0);
    if (sb_en && mem_we) begin
      if (exp_q.size() == 0) chk("unexpected_write", {10'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      else chk("sb_write", {10'd0, mem_addr, mem_wdata}, {10'd0, exp_q.pop_front()});
    end
    prev_we = mem_we;
  end

  // driver tasks
  task automatic cycle(input logic st, input logic vld, input logic [7:0] dat);
    start    = st;
    in_valid = vld;
    in_data  = dat;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    cycle(1'b1, 1'b0, 8'h00);
    chk("start_busy", busy, 1);
    chk("start_hold", cpu_hold, 1);
    chk("start_done", done, 0);
    chk("start_ready", in_ready, 1);
    chk("start_wl", words_loaded, 0);
    start = 1'b0;
  endtask

  // n back-to-back bytes (base+i); start pulsed at beats sp and sp+1
  task automatic run_stream(input int n, input int base, input int sp);
    logic [7:0] hi;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'((base + i) & 8'hFF);
      if (i % 2 == 0) hi = b;
      else exp_q.push_back({6'(i / 2), hi, b});
      cycle((i == sp) || (i == sp + 1), 1'b1, b);
      chk("beat_we", mem_we, (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 1) chk("beat_addr", mem_addr, i / 2);
      chk("beat_wl", words_loaded, i / 2);
      chk("beat_ready", in_ready, (i == 127) ? 0 : 1);
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_done();
    chk("flush_hold", cpu_hold, 1);
    cycle(1'b0, 1'b0, 8'h00);
    chk("done_done", done, 1);
    chk("done_wl", words_loaded, 64);
    chk("done_hold", cpu_hold, 0);
    chk("done_busy", busy, 0);
    chk("done_addr", mem_addr, 63);
    chk("done_we", mem_we, 0);
  endtask

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [6:0]  wl;
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{1'b0, 1'b1, 8'hAB, 1'b0, 6'd0, 16'h0000, 7'd0};
    vt[1]  = '{1'b0, 1'b0, 8'hEE, 1'b0, 6'd0, 16'h0000, 7'd0};
    vt[2]  = '{1'b0, 1'b0, 8'hEE, 1'b0, 6'd0, 16'h0000, 7'd0};
    vt[3]  = '{1'b1, 1'b0, 8'hEE, 1'b0, 6'd0, 16'h0000, 7'd0};
    vt[4]  = '{1'b0, 1'b0, 8'hEE, 1'b0, 6'd0, 16'h0000, 7'd0};
    vt[5]  = '{1'b0, 1'b0, 8'hEE, 1'b0, 6'd0, 16'h0000, 7'd0};
    vt[6]  = '{1'b0, 1'b1, 8'hCD, 1'b1, 6'd0, 16'hABCD, 7'd0};
    vt[7]  = '{1'b0, 1'b1, 8'h12, 1'b0, 6'd0, 16'h0000, 7'd1};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 16'h0000, 7'd1};
    vt[9]  = '{1'b0, 1'b1, 8'h34, 1'b1, 6'd1, 16'h1234, 7'd1};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 16'h0000, 7'd2};

    RST = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wl", words_loaded, 0);
    RST = 1'b0;
    sb_en = 1'b1;

    // full load of bytes 0x00..0x7F
    do_start();
    run_stream(128, 0, -10);
    check_done();

    // after done: stream ignored, then restart
    cycle(1'b0, 1'b1, 8'hFF);
    chk("after_done_ready", in_ready, 0);
    chk("after_done_we", mem_we, 0);
    cycle(1'b0, 1'b1, 8'hFF);
    chk("after_done_we2", mem_we, 0);
    chk("after_done_done", done, 1);
    do_start();

    // gapped vectors in the restarted session
    sb_en = 1'b0;
    for (int k = 0; k < 11; k++) begin
      cycle(vt[k].st, vt[k].vld, vt[k].dat);
      chk("tbl_we", mem_we, vt[k].we);
      chk("tbl_wl", words_loaded, vt[k].wl);
      chk("tbl_ready", in_ready, 1);
      if (vt[k].we) begin
        chk("tbl_addr", mem_addr, vt[k].addr);
        chk("tbl_wdata", mem_wdata, vt[k].wdata);
      end
    end
    sb_en = 1'b1;

    // fresh session with start pulses after 10 words
    RST = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    RST = 1'b0;
    do_start();
    run_stream(128, 8'h40, 20);
    check_done();

    // reset after the first byte of word 20
    do_start();
    run_stream(40, 3, -10);
    cycle(1'b0, 1'b1, 8'h99);
    RST = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    RST = 1'b0;
    chk("rst_mid_hold", cpu_hold, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_ready", in_ready, 0);
    chk("rst_mid_wl", words_loaded, 0);
    do_start();
    exp_q.push_back({6'd0, 16'h1122});
    cycle(1'b0, 1'b1, 8'h11);
    chk("reload_we0", mem_we, 0);
    cycle(1'b0, 1'b1, 8'h22);
    chk("reload_we", mem_we, 1);
    chk("reload_addr", mem_addr, 0);
    chk("reload_wdata", mem_wdata, 16'h1122);
    cycle(1'b0, 1'b0, 8'h00);
    chk("reload_wl", words_loaded, 1);

    repeat (2) cycle(1'b0, 1'b0, 8'h00);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
